// File: rtl/decode_general_register_pipe_pkg.sv
// Shared types and the single-channel decode rule for decode_general_register_pipe.
package decode_gpr_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_WORD  = 2'b01,
    SZ_DWORD = 2'b10
  } size_e;

  typedef struct packed {
    logic [7:0] onehot;
    logic [2:0] phys;
    logic       byte_high;
    size_e      size;
  } gpr_dec_t;

  localparam int unsigned GPR_DEC_W = $bits(gpr_dec_t);

  localparam logic [2:0] REG_EAX = 3'd0;
  localparam logic [2:0] REG_ECX = 3'd1;
  localparam logic [2:0] REG_EDX = 3'd2;
  localparam logic [2:0] REG_EBX = 3'd3;
  localparam logic [2:0] REG_ESP = 3'd4;
  localparam logic [2:0] REG_EBP = 3'd5;
  localparam logic [2:0] REG_ESI = 3'd6;
  localparam logic [2:0] REG_EDI = 3'd7;

  // The one-hot follows the encoding; byte codes 4..7 alias the high byte of regs 0..3.
  function automatic gpr_dec_t decode_one(input logic [2:0] reg_f,
                                          input logic       w_present,
                                          input logic       w,
                                          input logic       eff32);
    gpr_dec_t d;
    logic     is_byte;
    is_byte  = w_present & ~w;
    d.onehot = 8'b1000_0000 >> reg_f;
    if (is_byte) begin
      d.size      = SZ_BYTE;
      d.phys      = {1'b0, reg_f[1:0]};
      d.byte_high = reg_f[2];
    end else begin
      d.size      = eff32 ? SZ_DWORD : SZ_WORD;
      d.phys      = reg_f;
      d.byte_high = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_general_register_pipe_skid_buffer.sv
// Generic 2-entry valid/ready buffer: a registered head stage plus one skid entry.
module gpr_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic             head_valid_q, head_valid_d;
  logic             tail_valid_q, tail_valid_d;
  logic             ready_q, ready_d;
  logic             accept_s, drain_s;

  // Ready is a flop; gating with rst_n keeps it low while reset is held.
  assign in_ready_o  = ready_q & rst_n;
  assign accept_s    = in_valid_i & in_ready_o;
  assign drain_s     = head_valid_q & out_ready_i;
  assign out_valid_o = head_valid_q;
  assign out_data_o  = head_q;

  // Next-state for head/skid entries; the tail only fills while the head is stalled.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    head_valid_d = head_valid_q;
    tail_valid_d = tail_valid_q;
    if (!head_valid_q) begin
      if (accept_s) begin
        head_d       = in_data_i;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (drain_s) begin
      if (tail_valid_q) begin
        head_d       = tail_q;
        tail_valid_d = 1'b0;
      end else if (accept_s) begin
        head_d = in_data_i;
      end else begin
        head_valid_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        tail_d       = in_data_i;
        tail_valid_d = 1'b1;
      end else begin
        tail_valid_d = tail_valid_q;
      end
    end
    ready_d = ~(head_valid_d & tail_valid_d);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= {WIDTH{1'b0}};
      tail_q       <= {WIDTH{1'b0}};
      head_valid_q <= 1'b0;
      tail_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      head_valid_q <= head_valid_d;
      tail_valid_q <= tail_valid_d;
      ready_q      <= ready_d;
    end
  end

endmodule

// File: rtl/decode_general_register_pipe.sv
// Pipelined multi-channel GPR decoder behind a 2-entry skid buffer.
// Optional statistics counters are built when DECODE_GPR_STATS_EN is defined.
module decode_general_register_pipe #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ONEHOT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DECODE_GPR_STATS_EN
  input  logic                  stat_clear_i,
  output logic [31:0]           stat_accepted_o,
  output logic [31:0]           stat_byte_o,
  output logic [15:0]           stat_stall_o,
`endif
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  in_default_32_i,
  input  logic                  in_opsize_prefix_i,
  input  logic [NUM_CH-1:0]     in_w_present_i,
  input  logic [NUM_CH-1:0]     in_w_i,
  input  logic [3*NUM_CH-1:0]   in_reg_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [8*NUM_CH-1:0]   out_onehot_o,
  output logic [3*NUM_CH-1:0]   out_phys_o,
  output logic [NUM_CH-1:0]     out_byte_high_o,
  output logic [2*NUM_CH-1:0]   out_size_o
);

  import decode_gpr_pkg::*;

  if (ONEHOT_W != 8) begin : g_bad_onehot_w
    $error("decode_general_register_pipe: ONEHOT_W must be 8");
  end
  if ((NUM_CH < 1) || (NUM_CH > 4)) begin : g_bad_num_ch
    $error("decode_general_register_pipe: NUM_CH must be 1..4");
  end

  logic                    eff32_s;
  gpr_dec_t [NUM_CH-1:0]   dec_s;
  gpr_dec_t [NUM_CH-1:0]   head_s;

  assign eff32_s = in_default_32_i ^ in_opsize_prefix_i;

  // Decode every channel of the incoming request.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      dec_s[c] = decode_one(in_reg_i[3*c +: 3], in_w_present_i[c], in_w_i[c], eff32_s);
    end
  end

  gpr_skid_buffer #(
    .WIDTH (NUM_CH * GPR_DEC_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (dec_s),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (head_s)
  );

  // Flatten the registered head entry onto the per-channel output buses.
  always_comb begin
    out_onehot_o    = {(8*NUM_CH){1'b0}};
    out_phys_o      = {(3*NUM_CH){1'b0}};
    out_byte_high_o = {NUM_CH{1'b0}};
    out_size_o      = {(2*NUM_CH){1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      out_onehot_o[8*c +: 8] = head_s[c].onehot;
      out_phys_o[3*c +: 3]   = head_s[c].phys;
      out_byte_high_o[c]     = head_s[c].byte_high;
      out_size_o[2*c +: 2]   = head_s[c].size;
    end
  end

`ifdef DECODE_GPR_STATS_EN
  logic [31:0] acc_q, acc_d;
  logic [31:0] byte_q, byte_d;
  logic [15:0] stall_q, stall_d;
  logic [2:0]  byte_cnt_s;
  logic        accept_s, stall_s;

  assign accept_s        = in_valid_i & in_ready_o;
  assign stall_s         = out_valid_o & ~out_ready_i;
  assign stat_accepted_o = acc_q;
  assign stat_byte_o     = byte_q;
  assign stat_stall_o    = stall_q;

  // Number of byte-sized channels in the current request.
  always_comb begin
    byte_cnt_s = 3'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (dec_s[c].size == SZ_BYTE) begin
        byte_cnt_s = byte_cnt_s + 3'd1;
      end else begin
        byte_cnt_s = byte_cnt_s;
      end
    end
  end

  // Counter next-state; clear wins over any increment in the same cycle.
  always_comb begin
    acc_d   = acc_q;
    byte_d  = byte_q;
    stall_d = stall_q;
    if (stat_clear_i) begin
      acc_d   = 32'd0;
      byte_d  = 32'd0;
      stall_d = 16'd0;
    end else begin
      if (accept_s) begin
        acc_d  = acc_q + 32'd1;
        byte_d = byte_q + {29'd0, byte_cnt_s};
      end else begin
        acc_d  = acc_q;
        byte_d = byte_q;
      end
      if (stall_s) begin
        stall_d = stall_q + 16'd1;
      end else begin
        stall_d = stall_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= 32'd0;
      byte_q  <= 32'd0;
      stall_q <= 16'd0;
    end else begin
      acc_q   <= acc_d;
      byte_q  <= byte_d;
      stall_q <= stall_d;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_decode_general_register_pipe.sv
// Scoreboard bench for decode_general_register_pipe: random and directed requests
// checked against an arithmetic reference model; covers DECODE_GPR_STATS_EN when defined.
module tb_decode_general_register_pipe;

  localparam int NUM_CH = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid_i = 1'b0;
  logic                in_ready_o;
  logic                in_default_32_i = 1'b0;
  logic                in_opsize_prefix_i = 1'b0;
  logic [NUM_CH-1:0]   in_w_present_i = '0;
  logic [NUM_CH-1:0]   in_w_i = '0;
  logic [3*NUM_CH-1:0] in_reg_i = '0;
  logic                out_valid_o;
  logic                out_ready_i = 1'b0;
  logic [8*NUM_CH-1:0] out_onehot_o;
  logic [3*NUM_CH-1:0] out_phys_o;
  logic [NUM_CH-1:0]   out_byte_high_o;
  logic [2*NUM_CH-1:0] out_size_o;
`ifdef DECODE_GPR_STATS_EN
  logic                stat_clear_i = 1'b0;
  logic [31:0]         stat_accepted_o;
  logic [31:0]         stat_byte_o;
  logic [15:0]         stat_stall_o;
  logic [31:0]         m_acc, m_byte;
  logic [15:0]         m_stall;
`endif

  typedef struct {
    logic [8*NUM_CH-1:0] oh;
    logic [3*NUM_CH-1:0] ph;
    logic [NUM_CH-1:0]   bh;
    logic [2*NUM_CH-1:0] sz;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rand_ready = 1'b0;

  decode_general_register_pipe #(.NUM_CH(NUM_CH), .ONEHOT_W(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
`ifdef DECODE_GPR_STATS_EN
    .stat_clear_i       (stat_clear_i),
    .stat_accepted_o    (stat_accepted_o),
    .stat_byte_o        (stat_byte_o),
    .stat_stall_o       (stat_stall_o),
`endif
    .in_valid_i         (in_valid_i),
    .in_ready_o         (in_ready_o),
    .in_default_32_i    (in_default_32_i),
    .in_opsize_prefix_i (in_opsize_prefix_i),
    .in_w_present_i     (in_w_present_i),
    .in_w_i             (in_w_i),
    .in_reg_i           (in_reg_i),
    .out_valid_o        (out_valid_o),
    .out_ready_i        (out_ready_i),
    .out_onehot_o       (out_onehot_o),
    .out_phys_o         (out_phys_o),
    .out_byte_high_o    (out_byte_high_o),
    .out_size_o         (out_size_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: size from prefix/default/w, one-hot by code position, byte regs fold mod 4.
  function automatic exp_t model(input logic d32, input logic pre,
                                 input logic [NUM_CH-1:0] wp, input logic [NUM_CH-1:0] w,
                                 input logic [3*NUM_CH-1:0] r);
    exp_t e;
    int   rv;
    bit   eff32, is_byte;
    eff32 = (d32 != pre);
    for (int c = 0; c < NUM_CH; c++) begin
      rv      = int'(r[3*c +: 3]);
      is_byte = wp[c] && !w[c];
      e.oh[8*c +: 8] = 8'(1 << (7 - rv));
      if (is_byte) begin
        e.ph[3*c +: 3] = 3'(rv % 4);
        e.bh[c]        = 1'(rv / 4);
        e.sz[2*c +: 2] = 2'd0;
      end else begin
        e.ph[3*c +: 3] = 3'(rv);
        e.bh[c]        = 1'b0;
        e.sz[2*c +: 2] = eff32 ? 2'd2 : 2'd1;
      end
    end
    return e;
  endfunction

  function automatic logic [63:0] cur_vec();
    return 64'({out_onehot_o, out_phys_o, out_byte_high_o, out_size_o});
  endfunction

  task automatic monitor();
    logic [63:0] hold_vec;
    bit          hold_v;
    exp_t        e;
    int          nb;
    hold_v   = 1'b0;
    hold_vec = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        hold_v = 1'b0;
`ifdef DECODE_GPR_STATS_EN
        m_acc = '0; m_byte = '0; m_stall = '0;
`endif
      end else begin
        chk("in_ready_occupancy", 64'(in_ready_o), 64'(q.size() < 2));
        chk("out_valid_occupancy", 64'(out_valid_o), 64'(q.size() > 0));
`ifdef DECODE_GPR_STATS_EN
        chk("stat_accepted", 64'(stat_accepted_o), 64'(m_acc));
        chk("stat_byte", 64'(stat_byte_o), 64'(m_byte));
        chk("stat_stall", 64'(stat_stall_o), 64'(m_stall));
`endif
        if (hold_v && out_valid_o) chk("hold_stable", cur_vec(), hold_vec);
        hold_v   = out_valid_o && !out_ready_i;
        hold_vec = cur_vec();
        if (out_valid_o && out_ready_i) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got out_valid=1, expected empty scoreboard at %0t", $time);
          end else begin
            e = q.pop_front();
            chk("onehot", 64'(out_onehot_o), 64'(e.oh));
            chk("phys", 64'(out_phys_o), 64'(e.ph));
            chk("byte_high", 64'(out_byte_high_o), 64'(e.bh));
            chk("size", 64'(out_size_o), 64'(e.sz));
          end
        end
        nb = 0;
        if (in_valid_i && in_ready_o) begin
          q.push_back(model(in_default_32_i, in_opsize_prefix_i, in_w_present_i, in_w_i, in_reg_i));
          for (int c = 0; c < NUM_CH; c++) nb += (in_w_present_i[c] && !in_w_i[c]) ? 1 : 0;
        end
`ifdef DECODE_GPR_STATS_EN
        if (stat_clear_i) begin
          m_acc = '0; m_byte = '0; m_stall = '0;
        end else begin
          if (in_valid_i && in_ready_o) begin
            m_acc  = m_acc + 32'd1;
            m_byte = m_byte + 32'(nb);
          end
          if (out_valid_o && !out_ready_i) m_stall = m_stall + 16'd1;
        end
`endif
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready_i = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the request is taken, valid still high.
  task automatic send(input logic d32, input logic pre, input logic [NUM_CH-1:0] wp,
                      input logic [NUM_CH-1:0] w, input logic [3*NUM_CH-1:0] r);
    bit acc;
    int t;
    in_default_32_i    = d32;
    in_opsize_prefix_i = pre;
    in_w_present_i     = wp;
    in_w_i             = w;
    in_reg_i           = r;
    in_valid_i         = 1'b1;
    acc = 1'b0;
    t   = 0;
    while (!acc && t < 500) begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", t);
    end
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    in_reg_i   = 6'($urandom);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
    chk({tag, "_onehot"}, 64'(out_onehot_o), 64'd0);
    chk({tag, "_phys"}, 64'(out_phys_o), 64'd0);
    chk({tag, "_byte_high"}, 64'(out_byte_high_o), 64'd0);
    chk({tag, "_size"}, 64'(out_size_o), 64'd0);
  endtask

  initial begin
    int t;
    fork
      monitor();
      ready_drv();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready_o), 64'd0);
    check_zero_outputs("reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk); #1;
    out_ready_i = 1'b1;

    // Dword, both channels with w=1: EAX and EBX
    send(1'b1, 1'b0, 2'b11, 2'b11, {3'd3, 3'd0});
    chk("t1_valid", 64'(out_valid_o), 64'd1);
    chk("t1_onehot", 64'(out_onehot_o), 64'h1080);
    chk("t1_phys", 64'(out_phys_o), 64'(6'b011_000));
    chk("t1_size", 64'(out_size_o), 64'(4'b1010));
    idle();
    // Prefix flips to word size: SP and DX
    send(1'b1, 1'b1, 2'b00, 2'b00, {3'd2, 3'd4});
    chk("t2_onehot", 64'(out_onehot_o), 64'h2008);
    chk("t2_phys", 64'(out_phys_o), 64'(6'b010_100));
    chk("t2_byte_high", 64'(out_byte_high_o), 64'd0);
    chk("t2_size", 64'(out_size_o), 64'(4'b0101));
    // Byte size: BH on ch0, CL on ch1
    send(1'b1, 1'b0, 2'b11, 2'b00, {3'd1, 3'd7});
    chk("t3_onehot", 64'(out_onehot_o), 64'h4001);
    chk("t3_phys", 64'(out_phys_o), 64'(6'b001_011));
    chk("t3_byte_high", 64'(out_byte_high_o), 64'(2'b01));
    chk("t3_size", 64'(out_size_o), 64'd0);
    idle();

    // Backpressure: A and B fill both entries, C must wait
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    send(1'b1, 1'b0, 2'b00, 2'b00, {3'd2, 3'd1});
    send(1'b0, 1'b0, 2'b00, 2'b00, {3'd5, 3'd6});
    in_reg_i = {3'd4, 3'd3};
    chk("bp_in_ready_low", 64'(in_ready_o), 64'd0);
    chk("bp_hold_A", 64'(out_onehot_o), 64'h2040);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_in_ready_still_low", 64'(in_ready_o), 64'd0);
    chk("bp_still_A", 64'(out_onehot_o), 64'h2040);
    out_ready_i = 1'b1;
    send(1'b1, 1'b1, 2'b00, 2'b00, {3'd4, 3'd3});
    idle();
    repeat (4) begin @(posedge clk); #1; end

    // Reset with two entries held; in_valid stays high across release
    out_ready_i = 1'b0;
    send(1'b1, 1'b0, 2'b01, 2'b00, {3'd0, 3'd5});
    send(1'b1, 1'b0, 2'b10, 2'b00, {3'd6, 3'd2});
    idle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid_i = 1'b1;
    in_reg_i   = {3'd7, 3'd0};
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready_o), 64'd0);
    check_zero_outputs("midrst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(in_ready_o), 64'd1);
    check_zero_outputs("rel");
    @(posedge clk); #1;
    chk("first_cycle_accept", 64'(out_valid_o), 64'd1);
    idle();
    out_ready_i = 1'b1;

    // Randomised traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
`ifdef DECODE_GPR_STATS_EN
      stat_clear_i = (i == 200);
`endif
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end else begin
        send(1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 6'($urandom));
      end
    end
`ifdef DECODE_GPR_STATS_EN
    stat_clear_i = 1'b0;
`endif
    idle();
    rand_ready = 1'b0;
    out_ready_i = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_general_register_pipe.md
Name: decode_general_register_pipe

Overview:
Pipelined, multi-channel successor to the combinational GPR decoder. Each cycle it accepts one decode request carrying NUM_CH 3-bit register fields (e.g. channel 0 = reg, channel 1 = r/m). It resolves the effective operand size from the default size, the 0x66 prefix and the w bit, and emits per-channel one-hot selects, a physical register index, a byte-high flag and a size code. It sits between the ModR/M field extractor and the register-file read-port arbiter, behind a valid/ready handshake with a 2-entry skid buffer.

Parameters:
NUM_CH, 2, number of register fields decoded per request (1..4)
ONEHOT_W, 8, one-hot select width per channel (fixed 8; any other value is an elaboration error)

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_default_32  in  1  CS.D: 1 = 32-bit default operand size
in_opsize_prefix  in  1  0x66 prefix present; toggles the default size
in_w_present  in  NUM_CH  per-channel: a w field exists in the instruction
in_w  in  NUM_CH  per-channel w bit
in_reg  in  3*NUM_CH  per-channel register field, channel c at [3c+2:3c]
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_onehot  out  8*NUM_CH  per-channel; bit 7 = code 000 ... bit 0 = code 111
out_phys  out  3*NUM_CH  physical 32-bit register index accessed
out_byte_high  out  NUM_CH  1 = AH/CH/DH/BH
out_size  out  2*NUM_CH  00 byte, 01 word, 10 dword (11 never driven)

Behaviour:
- Interface decided: single clock clk; reset rst_n asynchronous, active-low.
- Effective width: eff32 = in_default_32 XOR in_opsize_prefix.
- Per channel c:
  - byte = w_present[c] && !w[c].
  - size = byte ? 00 : (eff32 ? 10 : 01).
  - onehot = 8'b1000_0000 >> reg[c] in all sizes. The one-hot position is the encoding position, not the physical register.
  - Byte size: phys = {1'b0, reg[1:0]}, byte_high = reg[2].
  - Otherwise: phys = reg, byte_high = 0.
- Pipeline: 1-cycle latency. A request accepted in cycle N is presented on out_* in cycle N+1 (registered outputs).
- Skid buffer: 2 entries, registered stage plus skid. in_ready is a registered signal, deasserted only when both entries are full. It never depends combinationally on out_ready.
- Ordering: strict FIFO order; no reordering.
- Data stability: out_* stays stable while out_valid && !out_ready.
- Simultaneous accept and drain when full: not possible, because in_ready = 0. When one entry is held, accepting and draining in the same cycle leaves occupancy unchanged.
- Empty: out_valid = 0; out_* hold their last value. Verification must not check out_* then.
- Reset mid-operation: all entries are discarded and occupancy goes to 0. The next in_valid after release is accepted in its first cycle.
- Reset values: in_ready 0 during reset, 1 in the first cycle after deassertion; out_valid 0; out_onehot all 0; out_phys 0; out_byte_high 0; out_size 0.
- in_valid with X on data fields while in_ready = 0 is legal; those fields are ignored.

Optional Feature:
DECODE_GPR_STATS_EN
- Defined: adds outputs stat_accepted (32), stat_byte (32) and stat_stall (16).
  - stat_accepted counts accepted requests.
  - stat_byte counts channels decoded at byte size.
  - stat_stall counts cycles with out_valid && !out_ready.
  - All counters wrap modulo 2^width, reset to 0, and clear synchronously on input stat_clear (1 bit). stat_clear has priority over increment in the same cycle.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package decode_gpr_pkg:
  - enum size_e {SZ_BYTE=2'b00, SZ_WORD=2'b01, SZ_DWORD=2'b10}
  - struct gpr_dec_t {onehot[7:0], phys[2:0], byte_high, size_e size}
  - localparam REG_EAX..REG_EDI = 0..7
  - function decode_one(reg, w_present, w, eff32) returning gpr_dec_t
- Sub-module gpr_skid_buffer: a generic 2-entry valid/ready buffer parameterised by payload width. It carries NUM_CH gpr_dec_t entries.

Test Plan:
1. Reset release, then in_default_32=1, prefix=0, w_present=11, w=11, reg={011,000} → next cycle out_valid=1; ch0 onehot=8'h80, size=10, phys=0; ch1 onehot=8'h10, phys=3.
2. default_32=1, prefix=1, w_present=0, reg ch0=100 → size=01, onehot=8'h08, phys=4 (SP), byte_high=0.
3. w_present=1, w=0, reg=111 → size=00, onehot=8'h01, phys=3, byte_high=1 (BH). With reg=001 → phys=1, byte_high=0 (CL).
4. Backpressure: out_ready=0, send 3 back-to-back requests A,B,C → A and B accepted; in_ready=0 from the cycle after B is accepted; out_* hold A. Raise out_ready → A, B, C emerge in order, no loss or duplication.
5. Assert rst_n=0 with 2 entries held, release → out_valid=0, all out_* zero, in_ready=1 the first cycle after release.
6. With DECODE_GPR_STATS_EN: 10 accepts with 3 byte channels and 4 stall cycles → stat_accepted=10, stat_byte=3, stat_stall=4. stat_clear during an accept → 0 the next cycle.
